// File: rtl/viterbi_err_sched_pkg.sv
// Shared types and constants for the Viterbi burst error scheduler.
// Holds the FSM state enum, the LFSR seed/taps and a 2-bit popcount helper.
package viterbi_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1 taps bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/viterbi_err_sched_if.sv
// Encoded symbol stream between encoder2, the error scheduler and the decoder.
// The master is the encoder/decoder side; the slave is the scheduler.
interface viterbi_err_sched_if;
  logic       sym_valid_i;
  logic [1:0] sym_i;
  logic       sym_valid_o;
  logic [1:0] sym_o;
  logic [1:0] err_inj_o;

  modport master (
    output sym_valid_i, sym_i,
    input  sym_valid_o, sym_o, err_inj_o
  );

  modport slave (
    input  sym_valid_i, sym_i,
    output sym_valid_o, sym_o, err_inj_o
  );
endinterface

// File: rtl/viterbi_err_sched_lfsr.sv
// 16-bit Fibonacci LFSR with seed load and step enable; used only when
// ERR_SCHED_LFSR_EN randomises the per-symbol burst mask.
module viterbi_err_lfsr
  import viterbi_err_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= {^(state & LFSR_TAPS), state[15:1]};
    end
  end

endmodule

// File: rtl/viterbi_err_sched.sv
// Burst error scheduler on the encoded symbol path (1-cycle latency).
// Optional ERR_SCHED_LFSR_EN: per-symbol mask = LFSR[1:0] & mask_i instead of mask_i.
module viterbi_err_sched
  import viterbi_err_pkg::*;
#(
  parameter int PER_W      = 5,
  parameter int BL_W       = 4,
  parameter int WORD_LIMIT = 256,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [PER_W-1:0]     period_i,
  input  logic [BL_W-1:0]      burst_len_i,
  input  logic [1:0]           mask_i,
  viterbi_err_sched_if.slave   sym,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     burst_ct_o,
  output logic [CNT_W-1:0]     bad_bit_ct_o
);

  localparam int WC_W = (WORD_LIMIT > 2) ? $clog2(WORD_LIMIT) : 1;

  sched_state_e      state, state_nxt;
  logic [PER_W-1:0]  period_q, phase, phase_nxt, period_m1;
  logic [BL_W-1:0]   burst_len_q, burst_idx, len_m1;
  logic [1:0]        mask_q, mask_eff, err;
  logic [WC_W-1:0]   word_ct;
  logic              start_ok, adv, inject, last_word, trig;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

`ifdef ERR_SCHED_LFSR_EN
  logic [15:0] lfsr_q;
  viterbi_err_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (adv),
    .load  (start_ok),
    .state (lfsr_q)
  );
  assign mask_eff = lfsr_q[1:0] & mask_q;
`else
  assign mask_eff = mask_q;
`endif

  always_comb begin
    start_ok  = start_i && (state == IDLE || state == DONE);
    adv       = sym.sym_valid_i && (state == ARM || state == BURST);
    inject    = sym.sym_valid_i && (state == BURST);
    err       = inject ? mask_eff : 2'b00;
    period_m1 = period_q - PER_W'(1);
    len_m1    = burst_len_q - BL_W'(1);
    last_word = (word_ct == WC_W'(WORD_LIMIT - 1));
    trig      = (period_q != '0) && (burst_len_q != '0) && (phase == period_m1);
    phase_nxt = (phase == period_m1) ? '0 : phase + PER_W'(1);
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start_i) state_nxt = ARM;
      ARM: begin
        if (adv && last_word)  state_nxt = DONE;
        else if (adv && trig)  state_nxt = BURST;
      end
      BURST: begin
        if (adv && last_word)                 state_nxt = DONE;
        else if (adv && burst_idx == len_m1)  state_nxt = ARM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register stage: state, statistics and the 1-cycle symbol pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      period_q         <= '0;
      burst_len_q      <= '0;
      mask_q           <= '0;
      word_ct          <= '0;
      phase            <= '0;
      burst_idx        <= '0;
      burst_ct_o       <= '0;
      bad_bit_ct_o     <= '0;
      sym.sym_valid_o  <= 1'b0;
      sym.sym_o        <= '0;
      sym.err_inj_o    <= '0;
    end else begin
      state           <= state_nxt;
      busy_o          <= (state_nxt == ARM) || (state_nxt == BURST);
      done_o          <= (state_nxt == DONE) && (state != DONE);
      sym.sym_valid_o <= sym.sym_valid_i;
      sym.sym_o       <= sym.sym_i ^ err;
      sym.err_inj_o   <= err;
      if (start_ok) begin
        period_q     <= period_i;
        burst_len_q  <= burst_len_i;
        mask_q       <= mask_i;
        word_ct      <= '0;
        phase        <= '0;
        burst_idx    <= '0;
        burst_ct_o   <= '0;
        bad_bit_ct_o <= '0;
      end else if (adv) begin
        word_ct   <= word_ct + WC_W'(1);
        phase     <= phase_nxt;
        burst_idx <= (state == BURST) ? burst_idx + BL_W'(1) : '0;
        if (inject) begin
          burst_ct_o   <= sat_add(burst_ct_o, 2'd1);
          bad_bit_ct_o <= sat_add(bad_bit_ct_o, popcount2(err));
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_err_sched.sv
// Random-stimulus bench for viterbi_err_sched against a symbol-index reference model.
module tb_viterbi_err_sched;
  localparam int LIMIT = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [4:0]  period_i;
  logic [3:0]  burst_len_i;
  logic [1:0]  mask_i;
  logic        busy_o, done_o;
  logic [15:0] burst_ct_o, bad_bit_ct_o;

  viterbi_err_sched_if sif();

  viterbi_err_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .period_i     (period_i),
    .burst_len_i  (burst_len_i),
    .mask_i       (mask_i),
    .sym          (sif.slave),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .burst_ct_o   (burst_ct_o),
    .bad_bit_ct_o (bad_bit_ct_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: k = index of valid symbol within the run, rem = burst symbols still owed.
  bit   m_active;
  int   m_k, m_rem, m_p, m_l, m_bct, m_bbt;
  logic [1:0] m_m;
  logic       e_valid, e_done, e_busy;
  logic [1:0] e_sym, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_k = 0; m_rem = 0; m_bct = 0; m_bbt = 0;
    m_p = 0; m_l = 0; m_m = 2'b00;
  endtask

  task automatic step(input bit st, input bit v, input bit r);
    logic [1:0] s;
    bit corrupt;
    s = 2'($urandom);
    corrupt = 0;
    @(negedge clk);
    rst = r; start_i = st; sif.sym_valid_i = v; sif.sym_i = s;
    e_done = 0;
    if (r) begin
      model_reset();
      e_valid = 0; e_sym = 2'b00; e_err = 2'b00;
    end else begin
      if (!m_active && st) begin
        m_active = 1; m_k = 0; m_rem = 0; m_bct = 0; m_bbt = 0;
        m_p = int'(period_i); m_l = int'(burst_len_i); m_m = mask_i;
      end else if (m_active && v) begin
        if (m_rem > 0) begin
          corrupt = 1;
          m_rem--;
          m_bct++;
          m_bbt += $countones(m_m);
        end else if (m_p != 0 && m_l != 0 && (m_k % m_p) == m_p - 1) begin
          m_rem = m_l;
        end
        if (m_k == LIMIT - 1) begin
          m_active = 0; m_rem = 0; e_done = 1;
        end
        m_k++;
      end
      e_valid = v;
      e_err   = corrupt ? m_m : 2'b00;
      e_sym   = s ^ e_err;
    end
    e_busy = m_active;
    @(posedge clk);
    #1;
    chk("sym_valid_o", 32'(sif.sym_valid_o), 32'(e_valid));
    chk("sym_o", 32'(sif.sym_o), 32'(e_sym));
    chk("err_inj_o", 32'(sif.err_inj_o), 32'(e_err));
    chk("done_o", 32'(done_o), 32'(e_done));
    chk("busy_o", 32'(busy_o), 32'(e_busy));
    chk("burst_ct_o", 32'(burst_ct_o), 32'(m_bct));
    chk("bad_bit_ct_o", 32'(bad_bit_ct_o), 32'(m_bbt));
  endtask

  task automatic run_syms(input int n, input int pct);
    int c = 0;
    while (c < n) begin
      bit v;
      v = ($urandom_range(99) < pct);
      step(0, v, 0);
      if (v) c++;
    end
  endtask

  task automatic start_run(input logic [4:0] p, input logic [3:0] l, input logic [1:0] m);
    period_i = p; burst_len_i = l; mask_i = m;
    step(1, 1'($urandom), 0);
  endtask

  initial begin
    rst = 1; start_i = 0; period_i = '0; burst_len_i = '0; mask_i = '0;
    sif.sym_valid_i = 0; sif.sym_i = '0;
    model_reset();

    // Reset state
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 0, 0);

    // period 8, len 3, mask 11: bursts at symbols 8-10, 16-18, ...
    start_run(5'd8, 4'd3, 2'b11);
    run_syms(64, 100);
    chk("p8_burst_ct_64", 32'(burst_ct_o), 32'd21);
    chk("p8_bad_bit_64", 32'(bad_bit_ct_o), 32'd42);
    // start while busy with a different config must be ignored
    period_i = 5'd2; burst_len_i = 4'd1; mask_i = 2'b01;
    step(1, 1, 0);
    run_syms(LIMIT - 65, 100);
    step(0, 0, 0);

    // period 32, len 3, mask 10; start coincident with DONE entry is ignored
    start_run(5'd32, 4'd3, 2'b10);
    run_syms(LIMIT - 1, 100);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    // period 4, len 6, mask 01: phase wraps inside the burst do not retrigger
    start_run(5'd4, 4'd6, 2'b01);
    run_syms(LIMIT, 85);
    step(0, 0, 0);

    // period 0 and len 0: pure pass-through, done still pulses
    start_run(5'd0, 4'd5, 2'b11);
    run_syms(LIMIT, 100);
    start_run(5'd7, 4'd0, 2'b11);
    run_syms(LIMIT, 100);

    // mask 00: bursts counted, no bits flipped
    start_run(5'd5, 4'd2, 2'b00);
    run_syms(LIMIT, 100);

    // period 8, len 2 with valid toggling about 50%
    start_run(5'd8, 4'd2, 2'b11);
    run_syms(LIMIT, 50);
    step(0, 0, 0);

    // period 1, len 15: back-to-back bursts separated by one clean symbol
    start_run(5'd1, 4'd15, 2'b10);
    run_syms(LIMIT, 90);

    // reset in the middle of a burst, then a fresh run counts from zero
    start_run(5'd3, 4'd4, 2'b11);
    run_syms(5, 100);
    step(0, 1, 1);
    step(0, 1, 0);
    start_run(5'd5, 4'd1, 2'b01);
    run_syms(40, 100);
    chk("post_rst_burst_ct", 32'(burst_ct_o), 32'd7);
    period_i = 5'd9;
    step(1, 1, 0);
    run_syms(LIMIT - 41, 70);
    step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
